// File: rtl/adc_pkg.sv
// Shared types and default widths for the ADC capture path.
package adc_pkg;

  localparam int unsigned DATA_W = 16;
  localparam int unsigned CNT_W  = 16;

  typedef enum logic [1:0] {
    IDLE    = 2'b00,
    ARMED   = 2'b01,
    CAPTURE = 2'b10,
    DRAIN   = 2'b11
  } cap_state_t;

endpackage

// File: rtl/capture_controller_edge_trigger.sv
// Rising threshold-crossing detector with a latched software force.
// o_trig_hit is only ever high on a valid sample while armed.
module edge_trigger
  import adc_pkg::*;
#(
  parameter int unsigned DATA_W = adc_pkg::DATA_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_armed,
  input  logic [DATA_W-1:0] i_adc_data,
  input  logic              i_adc_valid,
  input  logic              i_force_trig,
  input  logic [DATA_W-1:0] i_trig_level,
  output logic              o_trig_hit
);

  logic [DATA_W-1:0] r_prev_sample;
  logic              r_prev_valid;
  logic              r_force_pend;
  logic              w_cross;

  // A crossing needs a previous sample seen during this arming period.
  assign w_cross = r_prev_valid
                 & ($signed(r_prev_sample) < $signed(i_trig_level))
                 & ($signed(i_adc_data) >= $signed(i_trig_level));

  assign o_trig_hit = i_armed & i_adc_valid & (w_cross | i_force_trig | r_force_pend);

  // Force pulses without a sample wait for the next valid sample.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_prev_sample <= '0;
      r_prev_valid  <= 1'b0;
      r_force_pend  <= 1'b0;
    end else begin
      if (i_adc_valid) begin
        r_prev_sample <= i_adc_data;
      end
      r_prev_valid <= i_armed & (r_prev_valid | i_adc_valid);
      r_force_pend <= i_armed & ~i_adc_valid & (r_force_pend | i_force_trig);
    end
  end

endmodule

// File: rtl/capture_controller.sv
// Write-side controller for the ADC sample FIFO: arm, trigger, fill to
// full, then hold off until the reader has emptied the FIFO.
module capture_controller
  import adc_pkg::*;
#(
  parameter int unsigned DATA_W = adc_pkg::DATA_W,
  parameter int unsigned CNT_W  = adc_pkg::CNT_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [DATA_W-1:0] adc_data,
  input  logic              adc_valid,
  input  logic              arm,
  input  logic              force_trig,
  input  logic [DATA_W-1:0] trig_level,
  input  logic              full,
  input  logic              empty,
  output logic              wr_en,
  output logic [DATA_W-1:0] din,
  output logic              frame_done,
  output logic [CNT_W-1:0]  frame_len,
  output logic [CNT_W-1:0]  drop_cnt,
  output logic [1:0]        state
);

  cap_state_t       r_state;
  cap_state_t       w_next_state;
  logic [CNT_W-1:0] r_count;
  logic [CNT_W-1:0] r_frame_len;
  logic [CNT_W-1:0] r_drop_cnt;
  logic             r_frame_done;
  logic             w_trig_hit;
  logic             w_empty_ok;
  logic             w_start;
  logic             w_wr_en;

  edge_trigger #(.DATA_W(DATA_W)) u_edge_trigger (
    .clk          (clk),
    .rst          (rst),
    .i_armed      (r_state == ARMED),
    .i_adc_data   (adc_data),
    .i_adc_valid  (adc_valid),
    .i_force_trig (force_trig),
    .i_trig_level (trig_level),
    .o_trig_hit   (w_trig_hit)
  );

  // A FIFO reporting both full and empty is treated as full.
  assign w_empty_ok = empty & ~full;
  assign w_start    = (r_state == ARMED) & arm & w_trig_hit & ~full;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  always_comb begin
    w_next_state = r_state;
    case (r_state)
      IDLE:    if (arm && w_empty_ok) w_next_state = ARMED;
      ARMED: begin
        if (!arm)         w_next_state = IDLE;
        else if (w_start) w_next_state = CAPTURE;
      end
      CAPTURE: if (full) w_next_state = DRAIN;
      DRAIN:   if (w_empty_ok) w_next_state = arm ? ARMED : IDLE;
      default: w_next_state = IDLE;
    endcase
  end

  always_comb begin
    w_wr_en = 1'b0;
    case (r_state)
      ARMED:   w_wr_en = w_start;
      CAPTURE: w_wr_en = adc_valid & ~full;
      default: w_wr_en = 1'b0;
    endcase
    if (rst) w_wr_en = 1'b0;
  end

  // Frame counters; both sample counters saturate at all-ones.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_count      <= '0;
      r_frame_len  <= '0;
      r_drop_cnt   <= '0;
      r_frame_done <= 1'b0;
    end else begin
      r_frame_done <= (r_state == CAPTURE) & full;
      if (w_start) begin
        r_count <= CNT_W'(1);
      end else if ((r_state == CAPTURE) && w_wr_en && (r_count != '1)) begin
        r_count <= r_count + CNT_W'(1);
      end
      if ((r_state == CAPTURE) && adc_valid && full && (r_drop_cnt != '1)) begin
        r_drop_cnt <= r_drop_cnt + CNT_W'(1);
      end
      if ((r_state == CAPTURE) && full) begin
        r_frame_len <= r_count;
      end
    end
  end

  assign wr_en      = w_wr_en;
  assign din        = adc_data;
  assign frame_done = r_frame_done;
  assign frame_len  = r_frame_len;
  assign drop_cnt   = r_drop_cnt;
  assign state      = r_state;

endmodule

// File: tb/tb_capture_controller.sv
// Bench for capture_controller: directed scenarios with literal expectations
// plus randomized traffic checked every cycle against a behavioural model.
module tb_capture_controller;

  localparam int unsigned DW = 16;
  localparam int unsigned CW = 16;
  localparam int P_IDLE = 0, P_ARMED = 1, P_CAP = 2, P_DRAIN = 3;
  localparam int SAT = 65535;

  logic          clk = 1'b0;
  logic          rst, adc_valid, arm, force_trig, full, empty;
  logic [DW-1:0] adc_data, trig_level;
  logic          wr_en, frame_done;
  logic [DW-1:0] din;
  logic [CW-1:0] frame_len, drop_cnt;
  logic [1:0]    state;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  capture_controller dut (
    .clk        (clk),
    .rst        (rst),
    .adc_data   (adc_data),
    .adc_valid  (adc_valid),
    .arm        (arm),
    .force_trig (force_trig),
    .trig_level (trig_level),
    .full       (full),
    .empty      (empty),
    .wr_en      (wr_en),
    .din        (din),
    .frame_done (frame_done),
    .frame_len  (frame_len),
    .drop_cnt   (drop_cnt),
    .state      (state)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s actual=%0d required=%0d at t=%0t", name, act, exp, $time);
    end
  endtask

  function automatic int sx(input logic [DW-1:0] v);
    return int'($signed(v));
  endfunction

  // Behavioural model: phase, last sample, pending force, frame bookkeeping.
  int m_phase, m_prev, m_cnt, m_len, m_drop;
  bit m_prev_ok, m_pend, m_done;
  bit m_live = 1'b0;

  always @(negedge clk) begin
    bit hit, exp_wr, nxt_ok, nxt_pend, fifo_empty;
    int smp, nph;
    smp = sx(adc_data);
    fifo_empty = empty && !full;
    hit = (m_phase == P_ARMED) && adc_valid &&
          (force_trig || m_pend || (m_prev_ok && m_prev < sx(trig_level) && smp >= sx(trig_level)));
    exp_wr = !rst && (((m_phase == P_ARMED) && arm && hit && !full) ||
                      ((m_phase == P_CAP) && adc_valid && !full));
    if (m_live) begin
      check("state", 32'(state), 32'(m_phase));
      check("wr_en", 32'(wr_en), 32'(exp_wr));
      check("din", 32'(din), 32'(adc_data));
      check("frame_done", 32'(frame_done), 32'(m_done));
      check("frame_len", 32'(frame_len), 32'(m_len));
      check("drop_cnt", 32'(drop_cnt), 32'(m_drop));
      if (wr_en && full) check("wr_while_full", 32'(wr_en), 32'(0));
    end
    if (rst) begin
      m_phase = P_IDLE; m_prev = 0; m_prev_ok = 0; m_pend = 0;
      m_cnt = 0; m_len = 0; m_drop = 0; m_done = 0; m_live = 1'b1;
    end else begin
      nxt_ok   = (m_phase == P_ARMED) && (m_prev_ok || adc_valid);
      nxt_pend = (m_phase == P_ARMED) && !adc_valid && (m_pend || force_trig);
      m_done   = (m_phase == P_CAP) && full;
      nph = m_phase;
      case (m_phase)
        P_IDLE:  if (arm && fifo_empty) nph = P_ARMED;
        P_ARMED: begin
          if (!arm) nph = P_IDLE;
          else if (hit && !full) begin m_cnt = 1; nph = P_CAP; end
        end
        P_CAP: begin
          if (adc_valid && !full && m_cnt < SAT) m_cnt++;
          if (adc_valid && full && m_drop < SAT) m_drop++;
          if (full) begin m_len = m_cnt; nph = P_DRAIN; end
        end
        default: if (fifo_empty) nph = arm ? P_ARMED : P_IDLE;
      endcase
      m_phase = nph;
      if (adc_valid) m_prev = smp;
      m_prev_ok = nxt_ok;
      m_pend = nxt_pend;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input bit v, input int d);
    adc_valid = v;
    adc_data  = DW'(d);
  endtask

  initial begin
    rst = 1'b1; arm = 1'b0; force_trig = 1'b0; full = 1'b0; empty = 1'b0;
    adc_valid = 1'b0; adc_data = '0; trig_level = DW'(100);
    repeat (2) tick();
    rst = 1'b0;
    #1;
    check("rst_state", 32'(state), 32'(0));
    check("rst_wr_en", 32'(wr_en), 32'(0));
    check("rst_frame_len", 32'(frame_len), 32'(0));
    check("rst_drop_cnt", 32'(drop_cnt), 32'(0));

    // Level crossing 50, 90, 120, 130 against threshold 100.
    arm = 1'b1; empty = 1'b1;
    tick();
    check("armed_state", 32'(state), 32'(1));
    drive(1, 50);  #1 check("x50_wr", 32'(wr_en), 32'(0)); tick();
    drive(1, 90);  #1 check("x90_wr", 32'(wr_en), 32'(0)); tick();
    drive(1, 120); #1 check("x120_wr", 32'(wr_en), 32'(1)); tick();
    empty = 1'b0;
    drive(1, 130); #1 check("x130_wr", 32'(wr_en), 32'(1));
    check("x130_state", 32'(state), 32'(2));
    check("x130_din", 32'(din), 32'(130));
    tick();
    for (int i = 0; i < 3; i++) begin drive(1, 200 + i); tick(); end

    // Reset in the middle of a capture.
    rst = 1'b1; drive(1, 7);
    #1 check("rst_blocks_wr", 32'(wr_en), 32'(0));
    tick();
    rst = 1'b0; drive(0, 0);
    #1;
    check("midcap_rst_state", 32'(state), 32'(0));
    check("midcap_rst_wr", 32'(wr_en), 32'(0));
    check("midcap_rst_drop", 32'(drop_cnt), 32'(0));
    check("midcap_rst_len", 32'(frame_len), 32'(0));

    // No trigger from the first samples after arming.
    empty = 1'b1;
    tick();
    drive(1, 150); #1 check("nf150_wr", 32'(wr_en), 32'(0)); tick();
    drive(1, 200); #1 check("nf200_wr", 32'(wr_en), 32'(0)); tick();
    drive(0, 0); #1 check("nf_state", 32'(state), 32'(1));

    // Trigger then fill to 1024 samples, then full with data still arriving.
    drive(1, 50); tick();
    drive(1, 120); #1 check("fill_start_wr", 32'(wr_en), 32'(1)); tick();
    empty = 1'b0;
    for (int i = 1; i < 1024; i++) begin drive(1, i); tick(); end
    full = 1'b1; drive(1, 9);
    #1 check("full_wr", 32'(wr_en), 32'(0));
    tick();
    check("full_done", 32'(frame_done), 32'(1));
    check("full_state", 32'(state), 32'(3));
    check("full_len", 32'(frame_len), 32'(1024));
    check("full_drop", 32'(drop_cnt), 32'(1));
    tick();
    check("done_once", 32'(frame_done), 32'(0));
    check("drain_nodrop", 32'(drop_cnt), 32'(1));
    tick();

    // Drain, then re-arm because arm is still high.
    full = 1'b0; drive(0, 0);
    repeat (5) tick();
    check("drain_hold", 32'(state), 32'(3));
    empty = 1'b1;
    tick();
    check("rearm_state", 32'(state), 32'(1));

    // Force without a sample fires on the sample three cycles later.
    force_trig = 1'b1;
    #1 check("force_nowr", 32'(wr_en), 32'(0));
    tick();
    force_trig = 1'b0;
    tick(); tick();
    drive(1, -5);
    #1 check("force_late_wr", 32'(wr_en), 32'(1));
    tick();
    empty = 1'b0;
    for (int i = 0; i < 4; i++) begin drive(1, i); tick(); end
    full = 1'b1; tick();
    check("f2_len", 32'(frame_len), 32'(5));
    full = 1'b0; arm = 1'b0; drive(0, 0); empty = 1'b1;
    tick();
    check("drain_to_idle", 32'(state), 32'(0));

    // arm with a non-empty FIFO stays idle.
    empty = 1'b0; arm = 1'b1;
    repeat (3) tick();
    check("idle_hold", 32'(state), 32'(0));
    empty = 1'b1;
    tick();
    check("idle_to_armed", 32'(state), 32'(1));

    // Randomized traffic.
    for (int c = 0; c < 4000; c++) begin
      if (c % 200 == 0) trig_level = DW'(int'($urandom_range(0, 400)) - 200);
      rst        = ($urandom_range(0, 399) == 0);
      arm        = ($urandom_range(0, 9) != 0);
      adc_valid  = ($urandom_range(0, 9) < 7);
      adc_data   = DW'(int'($urandom_range(0, 800)) - 400);
      force_trig = ($urandom_range(0, 24) == 0);
      full       = ($urandom_range(0, 11) == 0);
      empty      = ($urandom_range(0, 9) < 4);
      tick();
    end
    rst = 1'b0; drive(0, 0); full = 1'b0;
    repeat (2) tick();
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
